// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the stb/cyc interface: word reads and byte-masked writes.
// Optional refresh windows that reject requests with retry: define DMEM_RESPONDER_REFRESH_EN.
module dmem_responder #(
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned REFRESH_PERIOD = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        action_stb,
  input  logic        action_cyc,
  input  logic        write,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  input  logic [1:0]  byte_enable,
  output logic [15:0] rdata,
  output logic        resp,
  output logic        retry
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [1:0]      be_q, be_d;
  logic [15:0]     mem [DEPTH];
  logic            req;
  logic            refresh_win;
  logic            unused_addr;

  assign req         = action_stb & action_cyc;
  assign unused_addr = ^{address[15:AW+1], address[0]};

`ifdef DMEM_RESPONDER_REFRESH_EN
  localparam int unsigned RW = $clog2(REFRESH_PERIOD);
  logic [RW-1:0] rcnt;

  // Free-running refresh phase counter; the last two counts form the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
    end else if (rcnt == RW'(REFRESH_PERIOD - 1)) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  assign refresh_win = (rcnt >= RW'(REFRESH_PERIOD - 2));
`else
  logic unused_cfg;
  assign unused_cfg  = (REFRESH_PERIOD < 4);
  assign refresh_win = 1'b0;
`endif

  assign retry = (state == IDLE) & req & refresh_win;

  // Next-state and transaction capture
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state)
      IDLE: begin
        if (req && !refresh_win) begin
          wr_d    = write;
          idx_d   = address[AW:1];
          wdata_d = wdata;
          be_d    = byte_enable;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // resp and rdata are loaded on the edge entering RESP so they are flop outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      resp    <= 1'b0;
      rdata   <= 16'h0000;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      resp    <= (state_d == RESP);
      if (state_d == RESP && !wr_d) begin
        rdata <= mem[idx_d];
      end
    end
  end

  // Array is not reset; writes commit on the edge that ends RESP
  always_ff @(posedge clk) begin
    if (state == RESP && wr_q) begin
      if (be_q[0]) mem[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem[idx_q][15:8] <= wdata_q[15:8];
    end
  end

endmodule
